// File: rtl/rsp_read_multi.sv
// CMD-line response receiver: short/long/R3 frames, NCR start-bit timeout, CRC7/index/end-bit checks.
// Define SDHCI_RSP_BUSY_EN to add the R1b DAT0 busy wait after the response.
module rsp_read_multi #(
  parameter int unsigned TimeoutCycles = 64,
  parameter int unsigned CntWidth      = 8,
  parameter bit          MaskOutput    = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clk_en_i,
  input  logic         cmd_i,
  input  logic         dat0_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [1:0]   rsp_type_i,
  input  logic [5:0]   cmd_idx_i,
  input  logic         rsp_busy_i,
  output logic         busy_o,
  output logic         receiving_o,
  output logic         done_o,
  output logic [119:0] rsp_o,
  output logic [5:0]   index_o,
  output logic         timeout_err_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         index_err_o,
  output logic         busy_done_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    SHIFT,
    CHECK
`ifdef SDHCI_RSP_BUSY_EN
    , BUSY_WAIT
`endif
  } state_t;

  state_t              state;
  logic [CntWidth-1:0] cnt;
  logic [126:0]        sr;
  logic [127:0]        sr_next;
  logic [6:0]          crc;
  logic [6:0]          crc_next;
  logic [1:0]          rtype;
  logic [5:0]          exp_idx;
  logic [119:0]        rsp_q;
  logic                rsp_valid;
  logic [5:0]          index_q;
  logic                timeout_err;
  logic                crc_err;
  logic                end_bit_err;
  logic                index_err;
  logic                done;
  logic                is_long;
  logic                last_bit;
  logic                crc_en;
  logic                fb;
`ifdef SDHCI_RSP_BUSY_EN
  logic                rbusy;
  logic                busy_done;
`endif

  // sr_next keeps b1 onward with the bit being sampled at [0], so the
  // CRC/end/index/payload fields land at fixed offsets for both frame lengths.
  always_comb begin
    is_long  = (rtype == 2'b10);
    sr_next  = {sr, cmd_i};
    last_bit = is_long ? (cnt == CntWidth'(135)) : (cnt == CntWidth'(47));
    crc_en   = is_long ? ((cnt >= CntWidth'(8)) && (cnt <= CntWidth'(127)))
                       : (cnt <= CntWidth'(39));
    fb       = crc[6] ^ cmd_i;
    crc_next = crc;
    if (crc_en) begin
      crc_next = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      crc         <= '0;
      rtype       <= '0;
      exp_idx     <= '0;
      rsp_q       <= '0;
      rsp_valid   <= 1'b0;
      index_q     <= '0;
      timeout_err <= 1'b0;
      crc_err     <= 1'b0;
      end_bit_err <= 1'b0;
      index_err   <= 1'b0;
      done        <= 1'b0;
`ifdef SDHCI_RSP_BUSY_EN
      rbusy       <= 1'b0;
      busy_done   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SDHCI_RSP_BUSY_EN
      busy_done <= 1'b0;
`endif
      if (abort_i && (state != IDLE)) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i && (rsp_type_i != 2'b00)) begin
              state     <= WAIT_START;
              cnt       <= '0;
              rtype     <= rsp_type_i;
              exp_idx   <= cmd_idx_i;
              rsp_valid <= 1'b0;
`ifdef SDHCI_RSP_BUSY_EN
              rbusy     <= rsp_busy_i;
`endif
            end
          end
          WAIT_START: begin
            if (clk_en_i) begin
              if (!cmd_i) begin
                state <= SHIFT;
                cnt   <= CntWidth'(1);
                crc   <= '0;
              end else if (cnt == CntWidth'(TimeoutCycles - 1)) begin
                state       <= CHECK;
                done        <= 1'b1;
                timeout_err <= 1'b1;
                crc_err     <= 1'b0;
                end_bit_err <= 1'b0;
                index_err   <= 1'b0;
                rsp_q       <= '0;
                index_q     <= '0;
              end else begin
                cnt <= cnt + CntWidth'(1);
              end
            end
          end
          SHIFT: begin
            if (clk_en_i) begin
              sr  <= sr_next[126:0];
              crc <= crc_next;
              cnt <= cnt + CntWidth'(1);
              if (last_bit) begin
                state       <= CHECK;
                done        <= 1'b1;
                rsp_valid   <= 1'b1;
                timeout_err <= 1'b0;
                end_bit_err <= ~cmd_i;
                crc_err     <= (rtype != 2'b11) && (crc != sr_next[7:1]);
                index_err   <= (rtype == 2'b01) &&
                               ((sr_next[45:40] != exp_idx) || sr_next[46]);
                if (is_long) begin
                  rsp_q   <= sr_next[127:8];
                  index_q <= '0;
                end else begin
                  rsp_q   <= {88'd0, sr_next[39:8]};
                  index_q <= sr_next[45:40];
                end
              end
            end
          end
          CHECK: begin
            cnt <= '0;
`ifdef SDHCI_RSP_BUSY_EN
            state <= (rbusy && !timeout_err) ? BUSY_WAIT : IDLE;
`else
            state <= IDLE;
`endif
          end
`ifdef SDHCI_RSP_BUSY_EN
          BUSY_WAIT: begin
            if (clk_en_i && dat0_i) begin
              state     <= IDLE;
              busy_done <= 1'b1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o        = (state != IDLE);
  assign receiving_o   = (state == SHIFT) || (state == CHECK);
  assign done_o        = done;
  assign rsp_o         = (MaskOutput && !rsp_valid) ? '0 : rsp_q;
  assign index_o       = index_q;
  assign timeout_err_o = timeout_err;
  assign crc_err_o     = crc_err;
  assign end_bit_err_o = end_bit_err;
  assign index_err_o   = index_err;

`ifdef SDHCI_RSP_BUSY_EN
  assign busy_done_o = busy_done;
`else
  logic unused_busy_inputs;
  assign unused_busy_inputs = dat0_i ^ rsp_busy_i;
  assign busy_done_o        = 1'b0;
`endif

endmodule

// File: tb/tb_rsp_read_multi.sv
// Directed bench for rsp_read_multi: short/long/R3 frames, timeout edge, reset/abort mid-frame, R1b busy.
module tb_rsp_read_multi;

  logic         clk;
  logic         rst;
  logic         clk_en;
  logic         cmd;
  logic         dat0;
  logic         start;
  logic         abort;
  logic [1:0]   rsp_type;
  logic [5:0]   cmd_idx;
  logic         rsp_busy;
  logic         busy_o;
  logic         receiving_o;
  logic         done_o;
  logic [119:0] rsp_o;
  logic [5:0]   index_o;
  logic         timeout_err_o;
  logic         crc_err_o;
  logic         end_bit_err_o;
  logic         index_err_o;
  logic         busy_done_o;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int done_cnt  = 0;
  int bdone_cnt = 0;
  int d0;
  int b0;

  logic [135:0] f_ok;
  logic [135:0] f_long;
  logic [135:0] f_r3;
  logic [119:0] long_pl;

  rsp_read_multi #(
    .TimeoutCycles(64),
    .CntWidth(8),
    .MaskOutput(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .clk_en_i(clk_en),
    .cmd_i(cmd),
    .dat0_i(dat0),
    .start_i(start),
    .abort_i(abort),
    .rsp_type_i(rsp_type),
    .cmd_idx_i(cmd_idx),
    .rsp_busy_i(rsp_busy),
    .busy_o(busy_o),
    .receiving_o(receiving_o),
    .done_o(done_o),
    .rsp_o(rsp_o),
    .index_o(index_o),
    .timeout_err_o(timeout_err_o),
    .crc_err_o(crc_err_o),
    .end_bit_err_o(end_bit_err_o),
    .index_err_o(index_err_o),
    .busy_done_o(busy_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (busy_done_o) bdone_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1);
  end

  function automatic logic [6:0] crc7(input logic [135:0] d, input int n);
    logic [6:0] c;
    logic       f;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      f = c[6] ^ d[i];
      c = {c[5:0], 1'b0} ^ (f ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [135:0] mk_short(input logic tbit, input logic [5:0] idx,
                                            input logic [31:0] pl, input logic [6:0] cx,
                                            input logic eb);
    logic [39:0] h;
    h = {1'b0, tbit, idx, pl};
    return {88'd0, h, crc7({96'd0, h}, 40) ^ cx, eb};
  endfunction

  function automatic logic [135:0] mk_long(input logic [119:0] pl, input logic [6:0] cx,
                                           input logic eb);
    return {2'b00, 6'h3F, pl, crc7({16'd0, pl}, 120) ^ cx, eb};
  endfunction

  function automatic logic [3:0] flags();
    return {timeout_err_o, crc_err_o, end_bit_err_o, index_err_o};
  endfunction

  task automatic check(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is high across exactly one rising edge.
  task automatic arm(input logic [1:0] t, input logic [5:0] idx, input logic b);
    start    = 1'b1;
    rsp_type = t;
    cmd_idx  = idx;
    rsp_busy = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One bit every 4 clocks; returns at the negedge just after the sampling edge.
  task automatic strobe(input logic c);
    repeat (3) @(negedge clk);
    cmd    = c;
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic send_bits(input logic [135:0] f, input int len, input int first, input int last);
    for (int i = first; i <= last; i++) strobe(f[len - 1 - i]);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; cmd = 1'b1; dat0 = 1'b1; start = 1'b0; abort = 1'b0;
    rsp_type = 2'b00; cmd_idx = 6'd0; rsp_busy = 1'b0;
    long_pl = 120'h0102030405060708090A0B0C0D0E0F;
    f_ok    = mk_short(1'b0, 6'd17, 32'h0000_0900, 7'h00, 1'b1);
    f_long  = mk_long(long_pl, 7'h01, 1'b0);
    f_r3    = mk_short(1'b0, 6'd63, 32'hDEAD_BEEF, 7'h01, 1'b1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy_o, 1'b0);
    check("rst_recv", receiving_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_rsp", rsp_o, 120'h0);
    check("rst_index", index_o, 6'd0);
    check("rst_flags", flags(), 4'b0000);

    arm(2'b00, 6'd17, 1'b0);
    check("type00_ignored", busy_o, 1'b0);

    // short R1, matching index
    d0 = done_cnt;
    arm(2'b01, 6'd17, 1'b0);
    check("t1_busy_armed", busy_o, 1'b1);
    strobe(1'b1);
    strobe(1'b1);
    check("t1_not_receiving", receiving_o, 1'b0);
    send_bits(f_ok, 48, 0, 47);
    check("t1_done_latency", done_o, 1'b1);
    check("t1_recv_in_check", receiving_o, 1'b1);
    check("t1_rsp", rsp_o, 120'h900);
    check("t1_index", index_o, 6'd17);
    check("t1_flags", flags(), 4'b0000);
    repeat (4) @(negedge clk);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_idle", busy_o, 1'b0);

    // same frame, different expected index
    arm(2'b01, 6'd18, 1'b0);
    send_bits(f_ok, 48, 0, 47);
    check("t2_done", done_o, 1'b1);
    check("t2_flags", flags(), 4'b0001);
    check("t2_rsp", rsp_o, 120'h900);
    repeat (4) @(negedge clk);

    // long frame, one CRC bit flipped and end bit 0
    arm(2'b10, 6'd2, 1'b0);
    send_bits(f_long, 136, 0, 135);
    check("long_done", done_o, 1'b1);
    check("long_flags", flags(), 4'b0110);
    check("long_rsp", rsp_o, long_pl);
    check("long_index", index_o, 6'd0);
    repeat (4) @(negedge clk);

    // start-bit timeout on the 64th strobe
    d0 = done_cnt;
    arm(2'b01, 6'd17, 1'b0);
    repeat (63) strobe(1'b1);
    check("to_63_no_done", done_o, 1'b0);
    check("to_63_busy", busy_o, 1'b1);
    strobe(1'b1);
    check("to_64_done", done_o, 1'b1);
    check("to_flags", flags(), 4'b1000);
    check("to_rsp", rsp_o, 120'h0);
    check("to_index", index_o, 6'd0);
    repeat (4) @(negedge clk);
    check("to_done_once", done_cnt - d0, 1);
    check("to_idle", busy_o, 1'b0);

    // R3: CRC and index ignored
    arm(2'b11, 6'd5, 1'b0);
    send_bits(f_r3, 48, 0, 47);
    check("r3_done", done_o, 1'b1);
    check("r3_flags", flags(), 4'b0000);
    check("r3_rsp", rsp_o, 120'hDEADBEEF);
    check("r3_index", index_o, 6'd63);
    repeat (4) @(negedge clk);

    // start bit arriving on the 64th strobe beats the timeout
    arm(2'b01, 6'd17, 1'b0);
    repeat (63) strobe(1'b1);
    send_bits(f_ok, 48, 0, 0);
    check("s64_no_done", done_o, 1'b0);
    check("s64_receiving", receiving_o, 1'b1);
    send_bits(f_ok, 48, 1, 47);
    check("s64_done", done_o, 1'b1);
    check("s64_flags", flags(), 4'b0000);
    check("s64_rsp", rsp_o, 120'h900);
    repeat (4) @(negedge clk);

    // reset at bit 20, then immediate re-arm
    d0 = done_cnt;
    arm(2'b01, 6'd17, 1'b0);
    send_bits(f_ok, 48, 0, 20);
    check("rstmid_receiving", receiving_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", busy_o, 1'b0);
    check("rstmid_done", done_o, 1'b0);
    check("rstmid_index", index_o, 6'd0);
    arm(2'b01, 6'd18, 1'b0);
    check("rstmid_rearm", busy_o, 1'b1);
    send_bits(f_ok, 48, 0, 47);
    check("rstmid_new_done", done_o, 1'b1);
    check("rstmid_new_flags", flags(), 4'b0001);
    repeat (4) @(negedge clk);
    check("rstmid_done_once", done_cnt - d0, 1);

    // abort at bit 20, outputs hold, immediate re-arm
    d0 = done_cnt;
    arm(2'b01, 6'd17, 1'b0);
    check("abort_rsp_masked", rsp_o, 120'h0);
    send_bits(f_ok, 48, 0, 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy_o, 1'b0);
    check("abort_done", done_o, 1'b0);
    check("abort_index_held", index_o, 6'd17);
    check("abort_flags_held", flags(), 4'b0001);
    arm(2'b01, 6'd17, 1'b0);
    check("abort_rearm", busy_o, 1'b1);
    send_bits(f_ok, 48, 0, 47);
    check("abort_new_flags", flags(), 4'b0000);
    check("abort_new_rsp", rsp_o, 120'h900);
    repeat (4) @(negedge clk);
    check("abort_done_once", done_cnt - d0, 1);

    // R1b: DAT0 low for 10 strobes after the end bit
    b0 = bdone_cnt;
    arm(2'b01, 6'd17, 1'b1);
    dat0 = 1'b0;
    send_bits(f_ok, 48, 0, 47);
    check("r1b_done", done_o, 1'b1);
    repeat (10) strobe(1'b1);
`ifdef SDHCI_RSP_BUSY_EN
    check("r1b_busy_hold", busy_o, 1'b1);
    check("r1b_no_early_pulse", bdone_cnt - b0, 0);
    dat0 = 1'b1;
    strobe(1'b1);
    check("r1b_busy_done", busy_done_o, 1'b1);
    check("r1b_idle", busy_o, 1'b0);
    repeat (4) @(negedge clk);
    check("r1b_pulse_once", bdone_cnt - b0, 1);
`else
    check("r1b_off_idle", busy_o, 1'b0);
    dat0 = 1'b1;
    strobe(1'b1);
    check("r1b_off_no_pulse", busy_done_o, 1'b0);
    repeat (4) @(negedge clk);
    check("r1b_off_pulse_cnt", bdone_cnt - b0, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rsp_read_multi.md
Name: rsp_read_multi

Overview:
- Parametrised CMD-line response receiver; successor to the fixed short/long receiver.
- Supports four per-transaction response modes and an internal start-bit timeout counter.
- Checks command index, CRC7 and end bit; can optionally wait for card busy on DAT0.
- Sits between the command issuer (which arms it after the CMD end bit) and the response/interrupt status registers.

Parameters:
- TimeoutCycles, 64: max sampled SD-clock bits in WAIT_START before timeout (NCR); must be ≥2.
- CntWidth, 8: width of bit/timeout counter; must hold max(135, TimeoutCycles).
- MaskOutput, 1: if 1, rsp_o reads 0 whenever rsp_valid_q is 0; if 0, rsp_o always shows the holding register.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- clk_en_i  in  1  SD bit strobe; cmd_i/dat0_i sampled only when high
- cmd_i  in  1  CMD line
- dat0_i  in  1  DAT0 line (busy sense)
- start_i  in  1  arm receiver (one-cycle pulse)
- abort_i  in  1  abandon current reception
- rsp_type_i  in  2  00 none, 01 short+CRC+index, 10 long 136-bit, 11 short no CRC/index (R3); sampled with start_i
- cmd_idx_i  in  6  expected index; sampled with start_i
- rsp_busy_i  in  1  response is R1b; sampled with start_i
- busy_o  out  1  armed or receiving or busy-waiting
- receiving_o  out  1  start bit seen, frame in progress
- done_o  out  1  one-cycle pulse, flags below valid
- rsp_o  out  120  response payload
- index_o  out  6  received index (short only, else 0)
- timeout_err_o, crc_err_o, end_bit_err_o, index_err_o  out  1 each  status, valid with done_o
- busy_done_o  out  1  one-cycle pulse at end of DAT0 busy

Behaviour:
- Reset (rst_i high at a clk_i edge): state IDLE, all counters 0, all outputs 0, rsp_valid_q 0. Applies mid-frame; no done_o is produced.
- Received bits are numbered b0 (start) onward.
  - Short frame (48 bits): b0 start, b1 transmission, b2..b7 index, b8..b39 payload, b40..b46 CRC, b47 end.
  - Long frame (136 bits): b0..b7 header, b8..b127 payload, b128..b134 CRC, b135 end.
- States:
  - IDLE: start_i with rsp_type_i≠00 → WAIT_START next cycle; captures type/idx/busy and clears rsp_valid_q. start_i with type 00 is ignored. start_i in any other state is ignored.
  - WAIT_START: on each clk_en_i cycle:
    - cmd_i=0 → SHIFT, bit counter=1.
    - Otherwise timeout counter +1. When it reaches TimeoutCycles → CHECK with timeout_err.
    - Start bit wins if both happen on the same strobe.
  - SHIFT: each clk_en_i samples one bit and increments the counter. Sampling b47 (short) or b135 (long) → CHECK.
  - CHECK: exactly one clk_i cycle; done_o=1. Then → BUSY_WAIT (see optional feature) or IDLE.
- abort_i in any non-IDLE state → IDLE next cycle. No done_o; outputs keep their prior values. abort_i has priority over all transitions.
- Payload, latched in CHECK (MSB first):
  - Short: rsp_o[31:0]=b8..b39, rsp_o[119:32]=0, index_o=b2..b7.
  - Long: rsp_o=b8..b127, index_o=0.
  - Timeout: rsp_o zeroed, rsp_valid_q stays 0.
  - rsp_valid_q set on non-timeout CHECK; value held until next accepted start_i.
- CRC7 (x^7+x^3+1, zero init): over b0..b39 (short) or b8..b127 (long), compared to received CRC bits. Computed serially in SHIFT, no extra latency.
- Flags (meaningful only in the done_o cycle; held afterwards until next start):
  - crc_err: mismatch, modes 01/10 only.
  - index_err: mode 01 and (index≠cmd_idx_i or b1≠0).
  - end_bit_err: end bit = 0.
  - On timeout only timeout_err_o=1; the others are 0.
- Latency: done_o exactly 1 clk_i cycle after the clk_i edge sampling the last bit.
- busy_o high from the cycle after an accepted start_i until return to IDLE. receiving_o high in SHIFT and CHECK.

Optional Feature:
- Macro SDHCI_RSP_BUSY_EN.
- Defined: after CHECK with captured rsp_busy_i=1 and no timeout, enter BUSY_WAIT.
  - busy_o stays high.
  - On the first clk_en_i with dat0_i=1 → IDLE, with busy_done_o pulsed that cycle.
  - No busy timeout; abort_i exits without the pulse.
- Undefined: BUSY_WAIT is absent, dat0_i/rsp_busy_i are ignored, busy_done_o is tied 0.

Test Plan:
- Short mode 01, cmd_idx_i=17, valid frame with index 17, payload 0x00000900, correct CRC, clk_en_i every 4 clks:
  - done_o once, rsp_o=0x900, index_o=17, all errors 0.
- Same frame with cmd_idx_i=18:
  - index_err_o=1, crc_err_o=0.
- Long mode 10, CID payload with one flipped CRC bit and end bit 0:
  - crc_err_o=1, end_bit_err_o=1, rsp_o=sent 120 bits.
- Mode 11, frame with wrong CRC and index 63:
  - crc_err_o=0, index_err_o=0, rsp_o[31:0] equals payload.
- cmd_i held 1 after start, TimeoutCycles=64:
  - done_o with timeout_err_o=1 on the 64th strobe.
  - Start bit on the 64th strobe instead → no timeout.
- rst_i (and separately abort_i) asserted at bit 20 of a short frame:
  - IDLE next cycle, no done_o, busy_o=0.
  - New start_i is accepted the following cycle.
- With SDHCI_RSP_BUSY_EN, R1b, dat0_i low for 10 strobes after end bit:
  - done_o, then busy_done_o on the strobe when dat0_i returns high.
